// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment patterns (bit 6 = a .. bit 0 = g)
// and the nibble decode used by every display block.
package seg7_pkg;

   localparam logic [6:0] SEG_0   = 7'b0000001;
   localparam logic [6:0] SEG_1   = 7'b1001111;
   localparam logic [6:0] SEG_2   = 7'b0010010;
   localparam logic [6:0] SEG_3   = 7'b0000110;
   localparam logic [6:0] SEG_4   = 7'b1001100;
   localparam logic [6:0] SEG_5   = 7'b0100100;
   localparam logic [6:0] SEG_6   = 7'b0100000;
   localparam logic [6:0] SEG_7   = 7'b0001111;
   localparam logic [6:0] SEG_8   = 7'b0000000;
   localparam logic [6:0] SEG_9   = 7'b0000100;
   localparam logic [6:0] SEG_A   = 7'b0001000;
   localparam logic [6:0] SEG_B   = 7'b1100000;
   localparam logic [6:0] SEG_C   = 7'b0110001;
   localparam logic [6:0] SEG_D   = 7'b1000010;
   localparam logic [6:0] SEG_E   = 7'b0110000;
   localparam logic [6:0] SEG_F   = 7'b0111000;
   localparam logic [6:0] SEG_OFF = 7'b1111111;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] i_hex);
      logic [6:0] w_seg;
      case (i_hex)
         4'h0:    w_seg = SEG_0;
         4'h1:    w_seg = SEG_1;
         4'h2:    w_seg = SEG_2;
         4'h3:    w_seg = SEG_3;
         4'h4:    w_seg = SEG_4;
         4'h5:    w_seg = SEG_5;
         4'h6:    w_seg = SEG_6;
         4'h7:    w_seg = SEG_7;
         4'h8:    w_seg = SEG_8;
         4'h9:    w_seg = SEG_9;
         4'hA:    w_seg = SEG_A;
         4'hB:    w_seg = SEG_B;
         4'hC:    w_seg = SEG_C;
         4'hD:    w_seg = SEG_D;
         4'hE:    w_seg = SEG_E;
         default: w_seg = SEG_F;
      endcase
      return w_seg;
   endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_to_7seg
   import seg7_pkg::*;
(
   input  logic [3:0] i_hex,
   output logic [6:0] o_seg
);

   assign o_seg = hex_to_seg(i_hex);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with per-digit blanking, blinking and
// decimal points. Every slot starts with one dark cycle to suppress ghosting.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned N_DIGITS    = 4,
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned BLINK_DIV   = 250
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [4*N_DIGITS-1:0]   i_value_in,
   input  logic                    i_load,
   input  logic [N_DIGITS-1:0]     i_blank_mask,
   input  logic [N_DIGITS-1:0]     i_blink_en,
   input  logic [N_DIGITS-1:0]     i_dp_in,
   output logic [6:0]              o_seg,
   output logic [N_DIGITS-1:0]     o_digit_sel,
   output logic                    o_dp
);

   localparam int unsigned CntW   = $clog2(REFRESH_DIV);
   localparam int unsigned IdxW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [CntW-1:0]   CntMax   = CntW'(REFRESH_DIV - 1);
   localparam logic [IdxW-1:0]   IdxMax   = IdxW'(N_DIGITS - 1);
   localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_DIV - 1);

   logic [4*N_DIGITS-1:0] r_value;
   logic [CntW-1:0]       r_cnt;
   logic [IdxW-1:0]       r_idx;
   logic [BlinkW-1:0]     r_blink_cnt;
   logic                  r_blink_phase;

   logic [3:0]            w_nibble;
   logic                  w_dark;
   logic                  w_dp_on;
   logic [N_DIGITS-1:0]   w_sel_n;
   logic [6:0]            w_seg;

   // Display value register; reset wins over load.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_value <= '0;
      end else if (i_load) begin
         r_value <= i_value_in;
      end
   end

   // Slot counter, scan index and blink frame counter, all advancing on slot wrap.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt         <= '0;
         r_idx         <= '0;
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
      end else if (r_cnt == CntMax) begin
         r_cnt <= '0;
         if (r_idx == IdxMax) begin
            r_idx <= '0;
            if (r_blink_cnt == BlinkMax) begin
               r_blink_cnt   <= '0;
               r_blink_phase <= ~r_blink_phase;
            end else begin
               r_blink_cnt <= r_blink_cnt + BlinkW'(1);
            end
         end else begin
            r_idx <= r_idx + IdxW'(1);
         end
      end else begin
         r_cnt <= r_cnt + CntW'(1);
      end
   end

   // Select the current digit's nibble, enable bit and live control bits.
   always_comb begin
      w_nibble = 4'h0;
      w_dark   = 1'b0;
      w_dp_on  = 1'b0;
      w_sel_n  = '1;
      for (int k = 0; k < N_DIGITS; k++) begin
         if (r_idx == IdxW'(k)) begin
            w_nibble   = r_value[4*k +: 4];
            w_dark     = i_blank_mask[k] | (i_blink_en[k] & r_blink_phase);
            w_dp_on    = i_dp_in[k];
            w_sel_n[k] = 1'b0;
         end
      end
   end

   hex_to_7seg u_hex_to_7seg (
      .i_hex (w_nibble),
      .o_seg (w_seg)
   );

   // Registered outputs: dark on the first slot cycle or when masked/blinked off.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_seg       <= SEG_OFF;
         o_digit_sel <= '1;
         o_dp        <= 1'b1;
      end else if ((r_cnt == '0) || w_dark) begin
         o_seg       <= SEG_OFF;
         o_digit_sel <= '1;
         o_dp        <= 1'b1;
      end else begin
         o_seg       <= w_seg;
         o_digit_sel <= w_sel_n;
         o_dp        <= ~w_dp_on;
      end
   end

endmodule
